// File: rtl/rv32i_mem_bridge.sv
// Data-side memory bridge for the RV32I MA stage: one load/store per request,
// performed as a single AXI4-Lite master transaction with lane steering and load extension.
module rv32i_mem_bridge (
  input  logic        clk,
  input  logic        rst_n,
  // core side
  input  logic        core_init_i,
  input  logic        core_mem_we_i,
  input  logic [2:0]  core_funct3_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_w_i,
  input  logic [4:0]  core_addr_d_i,
  input  logic        core_reg_we_i,
  output logic        core_stall_o,
  output logic        core_reg_we_o,
  output logic [4:0]  core_addr_d_o,
  output logic [31:0] core_data_d_o,
  output logic        err_o,
  // AXI4-Lite master
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        reg_we_q;
  logic [31:0] store_data;
  logic [3:0]  store_strb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Stall must be combinational so the core freezes in the request cycle itself.
  assign core_stall_o = ((state != IDLE) && (state != DONE)) ||
                        ((state == IDLE) && core_init_i);

  // Store steering from the live request; funct3[2] (unsigned) does not change the width.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    store_data = core_data_w_i;
    store_strb = 4'b1111;
    case (core_funct3_i[1:0])
      2'b00: begin
        store_data = {4{core_data_w_i[7:0]}};
        store_strb = 4'b0001 << core_addr_i[1:0];
      end
      2'b01: begin
        store_data = {2{core_data_w_i[15:0]}};
        store_strb = core_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load extraction uses the offset and size registered at acceptance.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off_q[1] ? rdata[31:16] : rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      reg_we_q      <= 1'b0;
      core_reg_we_o <= 1'b0;
      core_addr_d_o <= 5'd0;
      core_data_d_o <= 32'd0;
      err_o         <= 1'b0;
      awaddr        <= 32'd0;
      awvalid       <= 1'b0;
      wdata         <= 32'd0;
      wstrb         <= 4'd0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      araddr        <= 32'd0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      case (state)
        IDLE: begin
          if (core_init_i) begin
            funct3_q      <= core_funct3_i;
            off_q         <= core_addr_i[1:0];
            reg_we_q      <= core_reg_we_i;
            core_addr_d_o <= core_addr_d_i;
            if (core_mem_we_i) begin
              awaddr  <= {core_addr_i[31:2], 2'b00};
              wdata   <= store_data;
              wstrb   <= store_strb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR;
            end else begin
              araddr  <= {core_addr_i[31:2], 2'b00};
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        WR: begin
          // AW and W complete independently; leave once neither is still pending.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) err_o <= 1'b1;
            state  <= DONE;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready        <= 1'b0;
            if (rresp != 2'b00) err_o <= 1'b1;
            core_data_d_o <= load_data;
            core_reg_we_o <= reg_we_q;
            state         <= DONE;
          end
        end
        DONE: begin
          core_reg_we_o <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_bridge.sv
// Self-checking bench for rv32i_mem_bridge: directed and randomized loads/stores
// against a byte-lane reference model and a delay-configurable AXI4-Lite slave.
module tb_rv32i_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_init_i, core_mem_we_i, core_reg_we_i;
  logic [2:0]  core_funct3_i;
  logic [31:0] core_addr_i, core_data_w_i;
  logic [4:0]  core_addr_d_i;
  logic        core_stall_o, core_reg_we_o, err_o;
  logic [4:0]  core_addr_d_o;
  logic [31:0] core_data_d_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  rv32i_mem_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .core_init_i(core_init_i), .core_mem_we_i(core_mem_we_i),
    .core_funct3_i(core_funct3_i), .core_addr_i(core_addr_i),
    .core_data_w_i(core_data_w_i), .core_addr_d_i(core_addr_d_i),
    .core_reg_we_i(core_reg_we_i), .core_stall_o(core_stall_o),
    .core_reg_we_o(core_reg_we_o), .core_addr_d_o(core_addr_d_o),
    .core_data_d_o(core_data_d_o), .err_o(err_o),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // slave configuration and observations
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = 32'd0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, ar_got, b_fire, r_fire, aw_hold, w_hold;
  logic [31:0] aw_seen, w_seen, ar_seen, aw_prev, w_prev;
  logic [3:0]  strb_seen, strb_prev;
  int          w_beats = 0, stab_err = 0, we_pulses = 0;
  logic        err_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int lane_base(input logic [2:0] f3, input logic [31:0] addr);
    int sz = acc_size(f3);
    return (int'(addr % 4) / sz) * sz;
  endfunction

  // Each lane carries byte (lane mod size) of the right-aligned store data.
  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int sz = acc_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int sz = acc_size(f3);
    int b  = lane_base(f3, addr);
    for (int i = 0; i < 4; i++) s[i] = (i >= b) && (i < b + sz);
    return s;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
    longint v;
    longint span;
    int sz = acc_size(f3);
    span = longint'(1) << (8 * sz);
    v = (longint'(rd) >> (8 * lane_base(f3, addr))) % span;
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- AXI4-Lite slave (drives at negedge) ----------------
  initial begin : slave
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (core_reg_we_o) we_pulses++;
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        aw_hold = 0; w_hold = 0;
      end else begin
        // A valid left waiting last cycle must still be up with unchanged payload.
        if (aw_hold && (!awvalid || awaddr !== aw_prev)) stab_err++;
        if (w_hold && (!wvalid || wdata !== w_prev || wstrb !== strb_prev)) stab_err++;
        if (b_fire) bvalid = 0;
        if (aw_got && w_got && !bvalid) begin
          if (b_cnt >= b_delay) begin
            bvalid = 1; bresp = cfg_resp; aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        b_fire = bvalid && bready;
        awready = awvalid && (aw_cnt >= aw_delay);
        if (awvalid && !awready) aw_cnt++;
        if (awvalid && awready) begin aw_got = 1; aw_seen = awaddr; aw_cnt = 0; end
        if (wvalid) w_beats++;
        wready = wvalid && (w_cnt >= w_delay);
        if (wvalid && !wready) w_cnt++;
        if (wvalid && wready) begin w_got = 1; w_seen = wdata; strb_seen = wstrb; w_cnt = 0; end
        aw_hold = awvalid && !awready; aw_prev = awaddr;
        w_hold = wvalid && !wready; w_prev = wdata; strb_prev = wstrb;
        if (r_fire) rvalid = 0;
        if (ar_got && !rvalid) begin
          if (r_cnt >= r_delay) begin
            rvalid = 1; rdata = cfg_rdata; rresp = cfg_resp; ar_got = 0; r_cnt = 0;
          end else r_cnt++;
        end
        r_fire = rvalid && rready;
        arready = arvalid && (ar_cnt >= ar_delay);
        if (arvalid && !arready) ar_cnt++;
        if (arvalid && arready) begin ar_got = 1; ar_seen = araddr; ar_cnt = 0; end
      end
    end
  end

  // ---------------- one core request, checked end to end ----------------
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] d,
                        input logic [4:0] rd, input logic rwe, input int exp_lat);
    int   lat;
    int   p0;
    logic exp_we;
    exp_we = !we && rwe;
    @(negedge clk);
    w_beats = 0;
    p0 = we_pulses;
    core_init_i = 1; core_mem_we_i = we; core_funct3_i = f3;
    core_addr_i = addr; core_data_w_i = d; core_addr_d_i = rd; core_reg_we_i = rwe;
    #1;
    check({tag, "_stall_req"}, 32'(core_stall_o), 32'd1);
    @(negedge clk);
    core_init_i = 0;
    lat = 1;
    while (core_stall_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    if (lat >= 200) finish_sim();
    // now in the DONE cycle
    check({tag, "_reg_we"}, 32'(core_reg_we_o), 32'(exp_we));
    if (we) begin
      check({tag, "_awaddr"}, aw_seen, {addr[31:2], 2'b00});
      check({tag, "_wdata"}, w_seen, exp_wdata(f3, d));
      check({tag, "_wstrb"}, 32'(strb_seen), 32'(exp_wstrb(f3, addr)));
    end else begin
      check({tag, "_araddr"}, ar_seen, {addr[31:2], 2'b00});
      check({tag, "_data_d"}, core_data_d_o, exp_load(f3, addr, cfg_rdata));
      if (rwe) check({tag, "_addr_d"}, 32'(core_addr_d_o), 32'(rd));
    end
    if (cfg_resp != 2'b00) err_exp = 1'b1;
    check({tag, "_err"}, 32'(err_o), 32'(err_exp));
    @(negedge clk);
    check({tag, "_reg_we_off"}, 32'(core_reg_we_o), 32'd0);
    check({tag, "_pulses"}, we_pulses - p0, 32'(exp_we));
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  initial begin : stim
    int p0;
    int n;
    logic        we;
    logic [2:0]  f3;
    logic [2:0]  ld_f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    logic [2:0]  st_f3 [4] = '{3'b000, 3'b001, 3'b010, 3'b111};
    rst_n = 0;
    core_init_i = 0; core_mem_we_i = 0; core_funct3_i = 0; core_addr_i = 0;
    core_data_w_i = 0; core_addr_d_i = 0; core_reg_we_i = 0;
    #3;
    check("rst_stall", 32'(core_stall_o), 32'd0);
    check("rst_valids", {28'd0, awvalid, wvalid, arvalid, core_reg_we_o}, 32'd0);
    check("rst_readies", {29'd0, bready, rready, err_o}, 32'd0);
    check("rst_data_d", core_data_d_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // directed cases
    do_req("sw", 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 3);
    do_req("sb", 1, 3'b000, 32'h203, 32'h000000A5, 5'd0, 0, 3);
    cfg_rdata = 32'h0080_0000;
    do_req("lb", 0, 3'b000, 32'h302, 32'd0, 5'd5, 1, 3);
    cfg_rdata = 32'h8001_0000;
    do_req("lhu", 0, 3'b101, 32'h302, 32'd0, 5'd7, 1, 3);
    do_req("lh_neg", 0, 3'b001, 32'h303, 32'd0, 5'd8, 1, 3);
    do_req("lw_nowb", 0, 3'b010, 32'h304, 32'd0, 5'd9, 0, 3);
    do_req("sh_hi", 1, 3'b001, 32'h40F, 32'h1234_5678, 5'd0, 1, 3);

    // slow AW channel, immediate W
    aw_delay = 4;
    do_req("aw_slow", 1, 3'b010, 32'h500, 32'h0BAD_F00D, 5'd0, 0, 7);
    check("aw_slow_wbeats", w_beats, 1);
    check("aw_slow_stable", stab_err, 0);
    aw_delay = 0;

    // randomized traffic with random slave delays and occasional error responses
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? st_f3[$urandom_range(0, 3)] : ld_f3[$urandom_range(0, 5)];
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 2); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 2);
      cfg_rdata = $urandom;
      cfg_resp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      n = we ? max2(aw_delay, w_delay) + b_delay + 3 : ar_delay + r_delay + 3;
      do_req("rand", we, f3, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), n);
    end
    check("rand_stable", stab_err, 0);

    // clear the sticky error, then an erroring read followed by reset in RD_DATA
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    err_exp = 0;
    cfg_resp = 2'b10; cfg_rdata = 32'hCAFE_0123;
    do_req("rd_err", 0, 3'b010, 32'h600, 32'd0, 5'd3, 1, 3);
    cfg_resp = 2'b00;
    do_req("err_sticky", 1, 3'b010, 32'h604, 32'h1, 5'd0, 0, 3);

    r_delay = 5;
    @(negedge clk);
    p0 = we_pulses;
    core_init_i = 1; core_mem_we_i = 0; core_funct3_i = 3'b010;
    core_addr_i = 32'h700; core_addr_d_i = 5'd11; core_reg_we_i = 1;
    @(negedge clk);
    core_init_i = 0;
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    check("rst_mid_reach", 32'(rready), 32'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_mid_stall", 32'(core_stall_o), 32'd0);
    check("rst_mid_valids", {28'd0, awvalid, wvalid, arvalid, core_reg_we_o}, 32'd0);
    check("rst_mid_readies", {29'd0, bready, rready, err_o}, 32'd0);
    check("rst_mid_data_d", core_data_d_o, 32'd0);
    repeat (8) @(negedge clk);
    check("rst_mid_no_wb", we_pulses - p0, 0);
    rst_n = 1;
    r_delay = 0;
    err_exp = 0;
    cfg_rdata = 32'h0000_FF7F;
    do_req("post_rst_lb", 0, 3'b000, 32'h701, 32'd0, 5'd12, 1, 3);

    finish_sim();
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    finish_sim();
  end

endmodule

// File: doc/rv32i_mem_bridge.md
# rv32i_mem_bridge

Data-side responder for the RV32I core's memory-access (MA) stage. It accepts one load or store request per `core_init_i` pulse and stalls the core while the access is in flight. It performs the access as a single AXI4-Lite master transaction, handling byte-lane steering, strobes and load sign-extension. For loads it returns the result to the core's register-file write port.

## Interface
- Parameters: none; address and data are fixed at 32 bits.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset; asynchronous, active-low.
- `core_init_i` in 1 — request valid from MA stage; sampled only in IDLE.
- `core_mem_we_i` in 1 — 1 = store, 0 = load.
- `core_funct3_i` in 3 — access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `core_addr_i` in 32 — byte address.
- `core_data_w_i` in 32 — store data, right-aligned.
- `core_addr_d_i` in 5 — load destination register.
- `core_reg_we_i` in 1 — load result must be written back.
- `core_stall_o` out 1 — freezes the core pipeline.
- `core_reg_we_o` out 1 — one-cycle writeback strobe.
- `core_addr_d_o` out 5 — writeback register address.
- `core_data_d_o` out 32 — writeback data.
- `err_o` out 1 — sticky; set on any nonzero BRESP/RRESP.
- AXI4-Lite master ports, standard directions:
  - `awaddr` 32, `awvalid`, `awready`
  - `wdata` 32, `wstrb` 4, `wvalid`, `wready`
  - `bresp` 2, `bvalid`, `bready`
  - `araddr` 32, `arvalid`, `arready`
  - `rdata` 32, `rresp` 2, `rvalid`, `rready`

## Operation
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE accepting `core_init_i`=1:
  - Register funct3, addr[1:0], addr_d, reg_we.
  - Drive `awaddr`/`araddr` as {addr[31:2],2'b00}.
  - Store → WR; load → RD_ADDR.
- Store steering:
  - B: wdata = {4{d[7:0]}}, wstrb = 0001 << addr[1:0].
  - H: wdata = {2{d[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - W: wdata = d, wstrb = 1111.
  - Misaligned low bits are ignored: H uses addr[1] only; W ignores addr[1:0].
- WR:
  - `awvalid` and `wvalid` assert together.
  - Each drops independently on its own handshake.
  - Go to WR_RESP when both handshakes are done, including both completing in the same cycle.
- WR_RESP: `bready`=1; on `bvalid` → DONE.
- RD_ADDR: `arvalid`=1; on `arready` → RD_DATA.
- RD_DATA: `rready`=1; on `rvalid`, capture the extended `rdata` → DONE.
- Load extension: select byte addr[1:0] or half addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through.
- DONE:
  - `core_stall_o`=0.
  - `core_reg_we_o` = registered load && reg_we, with addr_d/data_d valid.
  - Next state is IDLE.
  - `core_init_i` is ignored in DONE.
- Error response:
  - Sets `err_o`.
  - Transaction completes normally; load data is returned as received.
- Unsupported funct3 values are treated as W.

## Timing
- Reset values: all outputs 0, including every valid/ready, `err_o` and `core_data_d_o`; state = IDLE.
- `core_stall_o` = (state ∉ {IDLE, DONE}) || (state==IDLE && `core_init_i`).
  - Combinational, so stall asserts in the same cycle as the request.
- All AXI outputs are registered.
  - valid rises the cycle after acceptance.
  - valid is never withdrawn before its handshake.
  - addr/data/strb are held stable while valid is high.
- Zero-wait slave latency, measured from acceptance edge to the DONE cycle:
  - Store: 3 cycles (WR, WR_RESP, DONE).
  - Load: 3 cycles (RD_ADDR, RD_DATA, DONE).
- Back-to-back requests: the earliest next acceptance is the cycle after DONE.
- Reset mid-transaction: return to IDLE at once, drop all valids, no writeback. The slave is reset with the same `rst_n`.
- `core_reg_we_o` is high for exactly one cycle per load with reg_we=1, and never for stores.

## Test plan
- SW to addr 0x100 with data 0xDEADBEEF, slave ready always high:
  - awaddr 0x100, wstrb 1111.
  - Stall high for 3 cycles, then a DONE cycle with no reg_we.
- SB to addr 0x203 with data 0x000000A5:
  - wdata 0xA5A5A5A5, wstrb 1000, awaddr 0x200.
- LB from addr 0x302, rdata 0x0080_0000, rd=5:
  - data_d 0xFFFFFF80, addr_d 5, reg_we pulses once.
- LHU from addr 0x302 with rdata 0x8001_0000:
  - data_d 0x00008001.
- Store with awready delayed 4 cycles and wready immediate:
  - wvalid drops after 1 cycle; awvalid is held with stable awaddr.
  - Stall persists until `bvalid`.
- Read returning rresp=10, then `rst_n` asserted during a later RD_DATA:
  - `err_o` is set by the first read and stays set.
  - The reset clears all outputs and produces no writeback.
